// File: rtl/db_pkg.sv
// db_pkg: shared definitions for the mini-batch bias-gradient accumulator.
//   - db_state_t     : controller states (IDLE, ACCUM, SCALE, OUT)
//   - CAPTURE_CODE_DEF : default controller phase code for delta capture
//   - FRAC, ONE      : Q-format constants (1.0 = ONE)
//   - sat_hi/sat_lo  : signed saturation bounds for a given result width
package db_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SCALE = 2'd2,
      OUT   = 2'd3
   } db_state_t;

   localparam logic [3:0]  CAPTURE_CODE_DEF = 4'd9;
   localparam int          FRAC             = 10;
   localparam logic [15:0] ONE              = 16'd1 << FRAC;

   // Largest value representable in a dw-bit two's complement word.
   function automatic logic signed [63:0] sat_hi(input int dw);
      return (64'sd1 <<< (dw - 1)) - 64'sd1;
   endfunction

   // Smallest value representable in a dw-bit two's complement word.
   function automatic logic signed [63:0] sat_lo(input int dw);
      return -(64'sd1 <<< (dw - 1));
   endfunction

endpackage

// File: rtl/db_lane.sv
// db_lane: one neuron lane of the bias-gradient accumulator.
// Sums sign-extended deltas into an AW-bit accumulator, then on scale_en
// registers (acc >>> LR_SHIFT) narrowed to DW bits.
// Optional feature macro: DB_SAT_EN (saturate on narrowing; otherwise wrap).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   acc_en      : add delta into accumulator this cycle
//   clr         : clear accumulator (batch handed off)
//   scale_en    : capture scaled/narrowed result
//   delta       : signed DW-bit input delta
//   result      : registered scaled gradient
module db_lane
   import db_pkg::*;
#(
   parameter int DW       = 16,
   parameter int AW       = 19,
   parameter int LR_SHIFT = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          acc_en,
   input  logic          clr,
   input  logic          scale_en,
   input  logic [DW-1:0] delta,
   output logic [DW-1:0] result
);

   logic signed [AW-1:0] acc_r;
   logic signed [AW-1:0] delta_ext_s;
   logic signed [AW-1:0] shifted_s;
   logic        [DW-1:0] narrow_s;

   assign delta_ext_s = AW'($signed(delta));
   // Arithmetic shift of a signed operand truncates toward minus infinity.
   assign shifted_s   = acc_r >>> LR_SHIFT;

`ifdef DB_SAT_EN
   logic signed [63:0] shifted_ext_s;
   logic signed [63:0] hi_s;
   logic signed [63:0] lo_s;

   assign shifted_ext_s = 64'(shifted_s);
   assign hi_s          = sat_hi(DW);
   assign lo_s          = sat_lo(DW);

   // Clamp the scaled sum into the DW-bit signed range.
   always_comb begin
      narrow_s = DW'(shifted_ext_s);
      if (shifted_ext_s > hi_s) begin
         narrow_s = DW'(hi_s);
      end else if (shifted_ext_s < lo_s) begin
         narrow_s = DW'(lo_s);
      end else begin
         narrow_s = DW'(shifted_ext_s);
      end
   end
`else
   // Keep only the low DW bits of the scaled sum.
   always_comb begin
      narrow_s = DW'(shifted_s);
   end
`endif

   // Lane accumulator: clear on handoff, add on accepted sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r <= {AW{1'b0}};
      end else if (clr) begin
         acc_r <= {AW{1'b0}};
      end else if (acc_en) begin
         acc_r <= acc_r + delta_ext_s;
      end else begin
         acc_r <= acc_r;
      end
   end

   // Result register: loaded once per batch in the scale cycle, then held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= {DW{1'b0}};
      end else if (scale_en) begin
         result <= narrow_s;
      end else begin
         result <= result;
      end
   end

endmodule

// File: rtl/db_batch_accum.sv
// db_batch_accum: N_CH-lane mini-batch bias-gradient accumulator.
// Captures deltas while step!=0 and controller==CAPTURE_CODE, sums BATCH
// samples (or fewer on flush), scales by 2^-LR_SHIFT and offers the result
// over a valid/ready handshake.
// Optional feature macro: DB_SAT_EN (saturating narrowing in each lane).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   step         : sequencer step, 0 = idle (no capture)
//   controller   : controller phase code
//   delta_in     : packed signed deltas, lane i at [i*DW +: DW]
//   in_valid/in_ready : input handshake (in_ready registered)
//   flush        : close the batch after the current sample
//   deltab_out   : packed scaled bias gradients
//   out_valid/out_ready : output handshake
//   sample_cnt   : samples accumulated in the current batch
module db_batch_accum
   import db_pkg::*;
#(
   parameter int         N_CH         = 4,
   parameter int         DW           = 16,
   parameter int         FRAC         = db_pkg::FRAC,
   parameter int         BATCH        = 8,
   parameter int         LR_SHIFT     = 5,
   parameter logic [3:0] CAPTURE_CODE = CAPTURE_CODE_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [3:0]                   step,
   input  logic [3:0]                   controller,
   input  logic [N_CH*DW-1:0]           delta_in,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         flush,
   output logic [N_CH*DW-1:0]           deltab_out,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(BATCH+1)-1:0]   sample_cnt
);

   localparam int AW = DW + $clog2(BATCH);
   localparam int CW = $clog2(BATCH + 1);

   db_state_t     state_r;
   db_state_t     next_state_s;
   logic          in_ready_r;
   logic          out_valid_r;
   logic [CW-1:0] cnt_r;
   logic          accept_s;
   logic          last_s;
   logic          acc_en_s;
   logic          scale_en_s;
   logic          clr_s;

   assign accept_s   = in_valid & in_ready_r & (step != 4'd0) &
                       (controller == CAPTURE_CODE);
   // This accept brings the batch to BATCH samples.
   assign last_s     = (cnt_r == CW'(BATCH - 1));
   assign in_ready   = in_ready_r;
   assign out_valid  = out_valid_r;
   assign sample_cnt = cnt_r;

   // Next-state and per-cycle lane controls.
   always_comb begin
      next_state_s = state_r;
      acc_en_s     = 1'b0;
      scale_en_s   = 1'b0;
      clr_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               acc_en_s = 1'b1;
               // A one-sample batch or a flushed first sample closes at once.
               if (last_s || flush) begin
                  next_state_s = SCALE;
               end else begin
                  next_state_s = ACCUM;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         ACCUM: begin
            if (accept_s) begin
               acc_en_s = 1'b1;
               if (last_s || flush) begin
                  next_state_s = SCALE;
               end else begin
                  next_state_s = ACCUM;
               end
            end else if (flush) begin
               next_state_s = SCALE;
            end else begin
               next_state_s = ACCUM;
            end
         end
         SCALE: begin
            scale_en_s   = 1'b1;
            next_state_s = OUT;
         end
         OUT: begin
            if (out_ready) begin
               clr_s        = 1'b1;
               next_state_s = IDLE;
            end else begin
               next_state_s = OUT;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State, registered handshake flags and sample counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         cnt_r       <= {CW{1'b0}};
      end else begin
         state_r     <= next_state_s;
         in_ready_r  <= (next_state_s == IDLE) || (next_state_s == ACCUM);
         out_valid_r <= (next_state_s == OUT);
         if (clr_s) begin
            cnt_r <= {CW{1'b0}};
         end else if (acc_en_s) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_lane
      db_lane #(
         .DW       (DW),
         .AW       (AW),
         .LR_SHIFT (LR_SHIFT)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .acc_en   (acc_en_s),
         .clr      (clr_s),
         .scale_en (scale_en_s),
         .delta    (delta_in[i*DW +: DW]),
         .result   (deltab_out[i*DW +: DW])
      );
   end

endmodule
